// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues in-order requests to a variable-latency
// instruction memory, buffers returned words and feeds decode one per cycle.
`timescale 1ns/1ps
module fetch_stage #(
  parameter int                   DataWidth   = 32,
  parameter logic [DataWidth-1:0] ResetVector = '0,
  parameter int                   FifoDepth   = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 stall,
  input  logic [1:0]           next_PC_sel,
  input  logic                 Branch,
  input  logic [DataWidth-1:0] BRANCH_TARGET,
  input  logic [DataWidth-1:0] JAL_TARGET,
  input  logic [DataWidth-1:0] JALR_TARGET,
  output logic                 imem_req,
  output logic [DataWidth-1:0] imem_addr,
  input  logic                 imem_gnt,
  input  logic                 imem_rvalid,
  input  logic [DataWidth-1:0] imem_rdata,
  output logic [DataWidth-1:0] Instruction_OUT,
  output logic [DataWidth-1:0] PC_OUT
);

  localparam int PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int CntW = $clog2(FifoDepth) + 1;
  localparam logic [DataWidth-1:0] Nop    = DataWidth'(32'h0000_0013);
  localparam logic [CntW:0]        Credit = (CntW+1)'(FifoDepth);

  logic [DataWidth-1:0] fetch_pc;

  logic [DataWidth-1:0] aq_mem [FifoDepth];
  logic [PtrW-1:0]      aq_rd;
  logic [PtrW-1:0]      aq_wr;

  logic [DataWidth-1:0] fifo_instr [FifoDepth];
  logic [DataWidth-1:0] fifo_pc    [FifoDepth];
  logic [PtrW-1:0]      fifo_rd;
  logic [PtrW-1:0]      fifo_wr;
  logic [CntW-1:0]      fifo_cnt;

  logic [CntW-1:0]      outstanding;
  logic [CntW-1:0]      discard;

  logic                 redirect;
  logic [DataWidth-1:0] target;
  logic [DataWidth-1:0] target_aligned;
  logic [CntW:0]        in_use;
  logic                 grant;
  logic                 drop;
  logic                 take;
  logic                 fifo_empty;
  logic                 normal;
  logic                 aq_push;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic [DataWidth-1:0] rsp_pc;
  logic [CntW-1:0]      outstanding_next;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    redirect = 1'b0;
    target   = BRANCH_TARGET;
    case (next_PC_sel)
      2'b01: redirect = Branch;
      2'b10: begin
        redirect = 1'b1;
        target   = JAL_TARGET;
      end
      2'b11: begin
        redirect = 1'b1;
        target   = JALR_TARGET;
      end
      default: redirect = 1'b0;
    endcase
  end

  assign target_aligned = target & ~DataWidth'(3);

  // Credit covers both in-flight words and buffered words, so a push never overflows.
  assign in_use    = {1'b0, outstanding} + {1'b0, fifo_cnt};
  assign imem_req  = !reset && (in_use < Credit);
  assign imem_addr = fetch_pc;

  assign grant      = imem_req && imem_gnt;
  assign drop       = imem_rvalid && (discard != '0);
  assign take       = imem_rvalid && (discard == '0);
  assign fifo_empty = (fifo_cnt == '0);
  assign rsp_pc     = aq_mem[aq_rd];

  assign normal    = !reset && !redirect;
  assign aq_push   = normal && grant;
  assign fifo_pop  = normal && !stall && !fifo_empty;
  assign fifo_push = normal && take && (stall || !fifo_empty);

  // Every response retires one in-flight request, whether it is kept or dropped.
  assign outstanding_next = outstanding + CntW'(grant) - CntW'(imem_rvalid);

  // NOTE: buffer storage carries no reset; the pointers and counts alone define validity.
  always_ff @(posedge clock) begin
    if (aq_push) aq_mem[aq_wr] <= fetch_pc;
    if (fifo_push) begin
      fifo_instr[fifo_wr] <= imem_rdata;
      fifo_pc[fifo_wr]    <= rsp_pc;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc        <= ResetVector;
      aq_rd           <= '0;
      aq_wr           <= '0;
      fifo_rd         <= '0;
      fifo_wr         <= '0;
      fifo_cnt        <= '0;
      outstanding     <= '0;
      discard         <= '0;
      Instruction_OUT <= Nop;
      PC_OUT          <= ResetVector;
    end else if (redirect) begin
      fetch_pc        <= target_aligned;
      aq_rd           <= '0;
      aq_wr           <= '0;
      fifo_rd         <= '0;
      fifo_wr         <= '0;
      fifo_cnt        <= '0;
      outstanding     <= outstanding_next;
      discard         <= outstanding_next;
      Instruction_OUT <= Nop;
    end else begin
      if (grant) begin
        aq_wr    <= aq_wr + 1'b1;
        fetch_pc <= fetch_pc + DataWidth'(4);
      end
      if (take) aq_rd <= aq_rd + 1'b1;
      if (drop) discard <= discard - 1'b1;
      outstanding <= outstanding_next;

      if (!stall) begin
        if (!fifo_empty) begin
          Instruction_OUT <= fifo_instr[fifo_rd];
          PC_OUT          <= fifo_pc[fifo_rd];
        end else if (take) begin
          Instruction_OUT <= imem_rdata;
          PC_OUT          <= rsp_pc;
        end else begin
          Instruction_OUT <= Nop;
        end
      end

      if (fifo_push) fifo_wr <= fifo_wr + 1'b1;
      if (fifo_pop)  fifo_rd <= fifo_rd + 1'b1;
      fifo_cnt <= fifo_cnt + CntW'(fifo_push) - CntW'(fifo_pop);
    end
  end

endmodule
